// File: rtl/video_pkg.sv
// Shared types and defaults for the raster timing path: the timing/pattern
// configuration record, sequencer states and the configuration legality rule.
package video_pkg;

  localparam int unsigned VID_W = 11;

  typedef logic [VID_W-1:0] vid_cnt_t;

  typedef struct packed {
    vid_cnt_t   col_total;
    vid_cnt_t   col_active;
    vid_cnt_t   row_total;
    vid_cnt_t   row_active;
    logic [1:0] pat;
  } vid_cfg_t;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vid_state_t;

  localparam vid_cnt_t VID_DEF_COL_TOTAL  = 11'd90;
  localparam vid_cnt_t VID_DEF_COL_ACTIVE = 11'd80;
  localparam vid_cnt_t VID_DEF_ROW_TOTAL  = 11'd70;
  localparam vid_cnt_t VID_DEF_ROW_ACTIVE = 11'd60;

  localparam vid_cfg_t VID_CFG_DEF = '{
    col_total:  VID_DEF_COL_TOTAL,
    col_active: VID_DEF_COL_ACTIVE,
    row_total:  VID_DEF_ROW_TOTAL,
    row_active: VID_DEF_ROW_ACTIVE,
    pat:        2'd0
  };

  // total > active also guarantees total >= 2, so total-1 never underflows
  function automatic logic cfg_is_valid(input vid_cfg_t c);
    return (c.col_active != '0) && (c.col_total > c.col_active) &&
           (c.row_active != '0) && (c.row_total > c.row_active);
  endfunction

endpackage

// File: rtl/video_cfg_shadow.sv
// Single-entry pending configuration slot with validation. Valid configs go
// straight to the active set while stopped, otherwise wait here for apply_i.
module video_cfg_shadow
  import video_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     cfg_valid_i,
  input  vid_cfg_t cfg_i,
  input  logic     running_i,
  input  logic     apply_i,
  output logic     cfg_ready_o,
  output logic     cfg_err_o,
  output logic     load_now_o,
  output logic     pend_valid_o,
  output vid_cfg_t pend_cfg_o
);

  logic     pend_valid_q, pend_valid_d;
  logic     err_q, err_d;
  vid_cfg_t pend_q, pend_d;
  logic     xfer;
  logic     ok;

  assign xfer = cfg_valid_i & ~pend_valid_q;
  assign ok   = cfg_is_valid(cfg_i);

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    err_d        = xfer & ~ok;
    if (apply_i) pend_valid_d = 1'b0;
    if (xfer && ok && running_i) begin
      pend_d       = cfg_i;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      err_q        <= 1'b0;
      pend_q       <= VID_CFG_DEF;
    end else begin
      pend_valid_q <= pend_valid_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
    end
  end

  assign cfg_ready_o  = ~pend_valid_q;
  assign cfg_err_o    = err_q;
  assign load_now_o   = xfer & ok & ~running_i;
  assign pend_valid_o = pend_valid_q;
  assign pend_cfg_o   = pend_q;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: row/column counters, DE/SOF/EOL markers and pattern select,
// with run/drain/stop control and frame-boundary configuration updates.
module video_timing_ctrl
  import video_pkg::*;
#(
  parameter logic [10:0] DEF_COL_TOTAL  = VID_DEF_COL_TOTAL,
  parameter logic [10:0] DEF_COL_ACTIVE = VID_DEF_COL_ACTIVE,
  parameter logic [10:0] DEF_ROW_TOTAL  = VID_DEF_ROW_TOTAL,
  parameter logic [10:0] DEF_ROW_ACTIVE = VID_DEF_ROW_ACTIVE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [10:0] cfg_col_total_i,
  input  logic [10:0] cfg_col_active_i,
  input  logic [10:0] cfg_row_total_i,
  input  logic [10:0] cfg_row_active_i,
  input  logic [1:0]  cfg_pat_i,
  output logic        cfg_err_o,
  output logic        running_o,
  output logic [10:0] col_o,
  output logic [10:0] row_o,
  output logic        de_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic [1:0]  pat_o
);

  localparam vid_cfg_t CFG_RST = '{
    col_total:  DEF_COL_TOTAL,
    col_active: DEF_COL_ACTIVE,
    row_total:  DEF_ROW_TOTAL,
    row_active: DEF_ROW_ACTIVE,
    pat:        2'd0
  };

  vid_state_t state_q;
  vid_cnt_t   col_q, row_q;
  vid_cfg_t   act_q;
  vid_cfg_t   cfg_in;
  vid_cfg_t   pend_cfg;
  logic       pend_valid;
  logic       load_now;
  logic       running, col_last, row_last, frame_last, apply;

  assign cfg_in = '{
    col_total:  cfg_col_total_i,
    col_active: cfg_col_active_i,
    row_total:  cfg_row_total_i,
    row_active: cfg_row_active_i,
    pat:        cfg_pat_i
  };

  assign running    = (state_q != ST_STOP);
  assign col_last   = (col_q == act_q.col_total - 11'd1);
  assign row_last   = (row_q == act_q.row_total - 11'd1);
  assign frame_last = running & col_last & row_last;
  assign apply      = frame_last & pend_valid;

  video_cfg_shadow u_shadow (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_i        (cfg_in),
    .running_i    (running),
    .apply_i      (apply),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_err_o    (cfg_err_o),
    .load_now_o   (load_now),
    .pend_valid_o (pend_valid),
    .pend_cfg_o   (pend_cfg)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_STOP;
      col_q   <= '0;
      row_q   <= '0;
      act_q   <= CFG_RST;
    end else begin
      // Counters only move while running; the last pixel always wraps to (0,0)
      if (running) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 11'd1;
        end else begin
          col_q <= col_q + 11'd1;
        end
        if (apply) act_q <= pend_cfg;
      end else if (load_now) begin
        act_q <= cfg_in;
      end

      // Re-enabling during drain wins over finishing the frame
      unique case (state_q)
        ST_STOP:  if (enable_i) state_q <= ST_RUN;
        ST_RUN:   if (!enable_i) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable_i)        state_q <= ST_RUN;
          else if (frame_last) state_q <= ST_STOP;
        end
        default:  state_q <= ST_STOP;
      endcase
    end
  end

  assign running_o = running;
  assign col_o     = col_q;
  assign row_o     = row_q;
  assign de_o      = running & (row_q < act_q.row_active) & (col_q < act_q.col_active);
  assign sof_o     = running & (col_q == '0) & (row_q == '0);
  assign eol_o     = running & col_last;
  assign pat_o     = act_q.pat;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: a frame-index reference model (pixel number
// within the frame, decoded with div/mod) checked against the DUT every cycle.
module tb_video_timing_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [10:0] cfg_col_total_i = '0;
  logic [10:0] cfg_col_active_i = '0;
  logic [10:0] cfg_row_total_i = '0;
  logic [10:0] cfg_row_active_i = '0;
  logic [1:0]  cfg_pat_i = '0;
  logic        cfg_err_o, running_o, de_o, sof_o, eol_o;
  logic [10:0] col_o, row_o;
  logic [1:0]  pat_o;

  video_timing_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_col_total_i(cfg_col_total_i), .cfg_col_active_i(cfg_col_active_i),
    .cfg_row_total_i(cfg_row_total_i), .cfg_row_active_i(cfg_row_active_i),
    .cfg_pat_i(cfg_pat_i), .cfg_err_o(cfg_err_o), .running_o(running_o),
    .col_o(col_o), .row_o(row_o), .de_o(de_o), .sof_o(sof_o), .eol_o(eol_o),
    .pat_o(pat_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  localparam logic [29:0] RST_VEC = {1'b0, 11'd0, 11'd0, 3'b000, 2'd0, 1'b1, 1'b0};

  typedef struct { int ct; int ca; int rt; int ra; int pat; } mcfg_t;

  // Model: stopped/running/draining, pixel index within frame, active + pending cfg
  mcfg_t m_cfg, m_pend;
  int    m_st, m_t;
  bit    m_pv, m_err;

  logic [29:0] obs;
  assign obs = {running_o, col_o, row_o, de_o, sof_o, eol_o, pat_o, cfg_ready_o, cfg_err_o};

  function automatic mcfg_t mk(int ct, int ca, int rt, int ra, int pat);
    mcfg_t c;
    c.ct = ct; c.ca = ca; c.rt = rt; c.ra = ra; c.pat = pat;
    return c;
  endfunction

  function automatic bit cfg_ok(mcfg_t c);
    return c.ca >= 1 && c.ct > c.ca && c.ra >= 1 && c.rt > c.ra;
  endfunction

  function automatic mcfg_t pins_cfg();
    return mk(int'(cfg_col_total_i), int'(cfg_col_active_i), int'(cfg_row_total_i),
              int'(cfg_row_active_i), int'(cfg_pat_i));
  endfunction

  function automatic logic [29:0] exp_vec();
    int c, r;
    bit run;
    run = (m_st != 0);
    c = run ? m_t % m_cfg.ct : 0;
    r = run ? m_t / m_cfg.ct : 0;
    return {run, 11'(c), 11'(r), 1'(run && r < m_cfg.ra && c < m_cfg.ca),
            1'(run && m_t == 0), 1'(run && c == m_cfg.ct - 1), 2'(m_cfg.pat),
            1'(!m_pv), m_err};
  endfunction

  task automatic model_reset();
    m_cfg = mk(90, 80, 70, 60, 0);
    m_pend = m_cfg;
    m_pv = 0; m_err = 0; m_st = 0; m_t = 0;
  endtask

  task automatic model_step();
    mcfg_t c;
    bit xfer, ok, last;
    c = pins_cfg();
    xfer = cfg_valid_i && !m_pv;
    ok = cfg_ok(c);
    last = (m_st != 0) && (m_t == m_cfg.ct * m_cfg.rt - 1);
    m_err = xfer && !ok;
    if (m_st == 0) begin
      if (xfer && ok) m_cfg = c;
      m_t = 0;
      if (enable_i) m_st = 1;
    end else begin
      m_t = last ? 0 : m_t + 1;
      if (last && m_pv) begin m_cfg = m_pend; m_pv = 0; end
      if (xfer && ok) begin m_pend = c; m_pv = 1; end
      if (m_st == 1) begin
        if (!enable_i) m_st = 2;
      end else if (enable_i) m_st = 1;
      else if (last) m_st = 0;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic set_cfg(int ct, int ca, int rt, int ra, int pat);
    cfg_col_total_i = 11'(ct); cfg_col_active_i = 11'(ca);
    cfg_row_total_i = 11'(rt); cfg_row_active_i = 11'(ra); cfg_pat_i = 2'(pat);
  endtask

  task automatic test_reset();
    rst_i = 1; enable_i = 0; cfg_valid_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    if (obs !== RST_VEC) begin errors++; $display("FAIL reset_vals got=%h want=%h", obs, RST_VEC); end
    checks++;
    rst_i = 0;
    step();
    if (obs !== RST_VEC) begin errors++; $display("FAIL reset_idle got=%h want=%h", obs, RST_VEC); end
    checks++;
  endtask

  task automatic test_frame();
    int de_n = 0, eol_n = 0;
    int sof_at[$];
    enable_i = 1;
    for (int i = 1; i <= 6301; i++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL frame_cyc i=%0d got=%h want=%h", i, obs, exp_vec()); end
      checks++;
      if (sof_o) sof_at.push_back(i);
      if (i <= 6300) begin de_n += int'(de_o); eol_n += int'(eol_o); end
    end
    if (sof_at.size() != 2 || sof_at[0] != 1 || sof_at[1] != 6301) begin
      errors++; $display("FAIL frame_period sof_count=%0d want 2 at 1 and 6301", sof_at.size());
    end
    checks++;
    if (de_n != 4800) begin errors++; $display("FAIL frame_de got=%0d want=4800", de_n); end
    checks++;
    if (eol_n != 70) begin errors++; $display("FAIL frame_eol got=%0d want=70", eol_n); end
    checks++;
  endtask

  task automatic test_drain();
    bit stayed = 1;
    int remain = 0, lc = -1, lr = -1;
    for (int n = 0; n < 7000 && m_t < 500; n++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL drain_pre got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    enable_i = 0;
    repeat (40) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL drain_mid got=%h want=%h", obs, exp_vec()); end
      checks++;
      if (!running_o) stayed = 0;
    end
    enable_i = 1;
    step();
    if (!stayed || running_o !== 1'b1 || col_o !== 11'd1 || row_o !== 11'd6) begin
      errors++; $display("FAIL drain_reenable run=%b col=%0d row=%0d want run=1 col=1 row=6", running_o, col_o, row_o);
    end
    checks++;
    for (int n = 0; n < 7000 && m_t != 2700; n++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL drain_go got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    enable_i = 0;
    while (running_o && remain < 7000) begin
      lc = int'(col_o); lr = int'(row_o);
      step();
      remain++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL drain_tail got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    if (remain != 3600) begin errors++; $display("FAIL drain_len got=%0d want=3600", remain); end
    checks++;
    if (lc != 89 || lr != 69) begin errors++; $display("FAIL drain_lastpix got=(%0d,%0d) want=(89,69)", lc, lr); end
    checks++;
    if ({running_o, col_o, row_o, de_o} !== 24'd0) begin
      errors++; $display("FAIL drain_stop run=%b col=%0d row=%0d de=%b want all 0", running_o, col_o, row_o, de_o);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int n, de_n;
    enable_i = 1;
    for (int k = 0; k < 2000 && (m_st == 0 || m_t < 1000); k++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL rstmid_pre got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    set_cfg(20, 16, 12, 10, 2); cfg_valid_i = 1;
    step();
    cfg_valid_i = 0;
    if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_pending ready=%b want=0", cfg_ready_o); end
    checks++;
    for (int k = 0; k < 2000 && m_t < 1840; k++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL rstmid_go got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    #2 rst_i = 1;
    #1;
    if (obs !== RST_VEC) begin errors++; $display("FAIL rstmid_async got=%h want=%h", obs, RST_VEC); end
    checks++;
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 0;
    step();
    if (sof_o !== 1'b1 || pat_o !== 2'd0 || cfg_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart sof=%b pat=%0d ready=%b want 1/0/1", sof_o, pat_o, cfg_ready_o);
    end
    checks++;
    n = 0; de_n = int'(de_o);
    for (int k = 0; k < 7000; k++) begin
      step(); n++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL rstmid_frame got=%h want=%h", obs, exp_vec()); end
      checks++;
      if (sof_o) break;
      de_n += int'(de_o);
    end
    if (n != 6300 || de_n != 4800) begin errors++; $display("FAIL rstmid_defaults len=%0d de=%0d want 6300/4800", n, de_n); end
    checks++;
  endtask

  task automatic test_pending_cfg();
    int stall_bad = 0, n = 0, de_n;
    for (int k = 0; k < 7000 && m_t < 3000; k++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL pend_pre got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    set_cfg(20, 16, 12, 10, 2); cfg_valid_i = 1;
    step();
    cfg_valid_i = 0;
    if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL pend_accept ready=%b want=0", cfg_ready_o); end
    checks++;
    for (int k = 0; k < 7000 && !sof_o; k++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL pend_wait got=%h want=%h", obs, exp_vec()); end
      checks++;
      if (!sof_o && cfg_ready_o) stall_bad++;
    end
    if (stall_bad != 0 || sof_o !== 1'b1) begin errors++; $display("FAIL pend_stall early_ready=%0d sof=%b want 0/1", stall_bad, sof_o); end
    checks++;
    if (pat_o !== 2'd2 || cfg_ready_o !== 1'b1) begin errors++; $display("FAIL pend_apply pat=%0d ready=%b want 2/1", pat_o, cfg_ready_o); end
    checks++;
    de_n = int'(de_o);
    for (int k = 0; k < 1000; k++) begin
      step(); n++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL pend_frame got=%h want=%h", obs, exp_vec()); end
      checks++;
      if (sof_o) break;
      de_n += int'(de_o);
    end
    if (n != 240 || de_n != 160) begin errors++; $display("FAIL pend_newframe len=%0d de=%0d want 240/160", n, de_n); end
    checks++;
  endtask

  task automatic test_invalid();
    int n = 0;
    set_cfg(10, 10, 5, 4, 1); cfg_valid_i = 1;
    step();
    cfg_valid_i = 0;
    if (cfg_err_o !== 1'b1 || cfg_ready_o !== 1'b1) begin errors++; $display("FAIL inv_pulse err=%b ready=%b want 1/1", cfg_err_o, cfg_ready_o); end
    checks++;
    step();
    if (obs !== exp_vec() || cfg_err_o !== 1'b0) begin errors++; $display("FAIL inv_clear got=%h want=%h", obs, exp_vec()); end
    checks++;
    for (int k = 0; k < 1000; k++) begin
      step(); n++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL inv_frame got=%h want=%h", obs, exp_vec()); end
      checks++;
      if (sof_o) break;
    end
    if (n != 238 || pat_o !== 2'd2) begin errors++; $display("FAIL inv_unchanged steps=%0d pat=%0d want 238/2", n, pat_o); end
    checks++;
  endtask

  task automatic test_stop_cfg();
    int early = 0, n = 0;
    bit rdy;
    enable_i = 0;
    for (int k = 0; k < 300 && running_o; k++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL stop_drain got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    set_cfg(12, 8, 6, 4, 1); cfg_valid_i = 1;
    step();
    cfg_valid_i = 0;
    if (pat_o !== 2'd1 || running_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      errors++; $display("FAIL stop_bypass pat=%0d run=%b ready=%b want 1/0/1", pat_o, running_o, cfg_ready_o);
    end
    checks++;
    enable_i = 1;
    step();
    if (obs !== exp_vec() || sof_o !== 1'b1 || de_o !== 1'b1) begin errors++; $display("FAIL stop_start got=%h want=%h", obs, exp_vec()); end
    checks++;
    set_cfg(16, 8, 10, 5, 3); cfg_valid_i = 1;
    step();
    set_cfg(14, 7, 9, 3, 2);
    for (int k = 0; k < 200 && !sof_o; k++) begin
      rdy = cfg_ready_o;
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL b2b_wait got=%h want=%h", obs, exp_vec()); end
      checks++;
      if (rdy) early++;
    end
    if (early != 0 || sof_o !== 1'b1 || pat_o !== 2'd3) begin
      errors++; $display("FAIL b2b_stall early=%0d sof=%b pat=%0d want 0/1/3", early, sof_o, pat_o);
    end
    checks++;
    step(); n = 1;
    cfg_valid_i = 0;
    if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_second ready=%b want=0", cfg_ready_o); end
    checks++;
    for (int k = 0; k < 400 && !sof_o; k++) begin
      step(); n++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL b2b_frame got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    if (n != 160 || pat_o !== 2'd2) begin errors++; $display("FAIL b2b_apply len=%0d pat=%0d want 160/2", n, pat_o); end
    checks++;
  endtask

  task automatic test_max_total();
    int n = 0, m;
    set_cfg(2047, 2047, 4, 2, 0); cfg_valid_i = 1;
    step();
    if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL max_reject err=%b want=1", cfg_err_o); end
    checks++;
    set_cfg(2047, 2046, 2, 1, 1);
    step();
    cfg_valid_i = 0;
    if (cfg_ready_o !== 1'b0 || cfg_err_o !== 1'b0) begin errors++; $display("FAIL max_accept ready=%b err=%b want 0/0", cfg_ready_o, cfg_err_o); end
    checks++;
    for (int k = 0; k < 200 && !sof_o; k++) begin
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL max_wait got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    for (int k = 0; k < 3000 && !eol_o; k++) begin
      step(); n++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL max_line got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    if (n != 2046 || col_o !== 11'd2046 || pat_o !== 2'd1) begin
      errors++; $display("FAIL max_eol steps=%0d col=%0d pat=%0d want 2046/2046/1", n, col_o, pat_o);
    end
    checks++;
    set_cfg(10, 6, 5, 3, 0); cfg_valid_i = 1;
    step(); m = n + 1;
    cfg_valid_i = 0;
    for (int k = 0; k < 5000 && !sof_o; k++) begin
      step(); m++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL max_frame got=%h want=%h", obs, exp_vec()); end
      checks++;
    end
    if (m != 4094 || pat_o !== 2'd0) begin errors++; $display("FAIL max_len len=%0d pat=%0d want 4094/0", m, pat_o); end
    checks++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      enable_i = ($urandom_range(0, 99) < 92);
      cfg_valid_i = ($urandom_range(0, 99) < 6);
      set_cfg($urandom_range(0, 14), $urandom_range(0, 12), $urandom_range(0, 9),
              $urandom_range(0, 7), $urandom_range(0, 3));
      step();
      if (obs !== exp_vec()) begin errors++; $display("FAIL random k=%0d got=%h want=%h", k, obs, exp_vec()); end
      checks++;
    end
    cfg_valid_i = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_drain();
    test_reset_mid();
    test_pending_cfg();
    test_invalid();
    test_stop_cfg();
    test_max_total();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
